// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: sequencer state encoding, reset fetch PC and queue entry layout.
package fetch_ctrl_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h1c000000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, inst} queue; a pushed entry is visible at the head the next cycle.
// Flush wins over push and pop; the producer must never push into a full queue.
module fetch_fifo2
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic [1:0]  count,
  output logic        head_vld,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);

  fetch_ent_t ent [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_pop;

  assign head_vld  = (count != 2'd0);
  assign do_pop    = pop && head_vld;
  assign head_pc   = ent[rd_ptr].pc;
  assign head_inst = ent[rd_ptr].inst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent[0] <= '0;
      ent[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        ent[wr_ptr].pc   <= push_pc;
        ent[wr_ptr].inst <= push_inst;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rstn) !(push && !flush && count == 2'd2));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding req/addr_ok/data_ok fetch, data reaches ID 2+ cycles after handshake.
// Requests stop while queued plus in-flight words would exceed two; redirect flushes the queue and kills the in-flight fetch.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic        redirect,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_allowin,
  output logic        fetch_busy
);

  fetch_state_t state;
  logic [31:0]  req_pc;
  logic [1:0]   q_count;
  logic [1:0]   rst_grace;
  logic         hs;
  logic         push;
  logic         pop;

  // Requests are only issued from REQ, so in-flight is zero whenever credit is evaluated.
  assign inst_req   = rstn && (state == FETCH_REQ) && (q_count != 2'd2);
  assign inst_addr  = pc;
  assign fetch_busy = (state != FETCH_REQ);
  assign hs         = inst_req && inst_addr_ok;
  assign pop        = if_valid && id_allowin;
  assign push       = (state == FETCH_WAIT) && inst_data_ok && !redirect;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= FETCH_REQ;
      pc        <= RESET_PC;
      req_pc    <= 32'h0;
      rst_grace <= 2'd3;
    end else begin
      if (hs || redirect) pc <= npc;
      if (hs) req_pc <= pc;
      if (rst_grace != 2'd0) rst_grace <= rst_grace - 2'd1;
      case (state)
        FETCH_REQ:  if (hs) state <= redirect ? FETCH_DROP : FETCH_WAIT;
        FETCH_WAIT: begin
          if (inst_data_ok)  state <= FETCH_REQ;
          else if (redirect) state <= FETCH_DROP;
        end
        FETCH_DROP: if (inst_data_ok) state <= FETCH_REQ;
        default:    state <= FETCH_REQ;
      endcase
    end
  end

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_pc   (req_pc),
    .push_inst (inst_rdata),
    .pop       (pop),
    .flush     (redirect),
    .count     (q_count),
    .head_vld  (if_valid),
    .head_pc   (if_pc),
    .head_inst (if_inst)
  );

  // Memory may still answer a fetch that reset killed, so stray data is tolerated briefly after reset.
  assert property (@(posedge clk) disable iff (!rstn)
                   !(inst_data_ok && state == FETCH_REQ && rst_grace == 2'd0));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: bench acts as NPC and instruction memory, with a queue-level reference model.
module tb_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] pc, npc, inst_addr, inst_rdata, if_pc, if_inst, tgt;
  logic        redirect, inst_req, inst_addr_ok, inst_data_ok, if_valid, id_allowin, fetch_busy;

  int          n_checks = 0;
  int          n_err = 0;
  int          lat;
  int          mem_cnt;
  bit          bad_word;
  logic [31:0] mem_dat;

  logic [31:0] m_pc, m_req_pc;
  bit          m_out, m_kill;
  logic [63:0] m_q[$];

  always #5 clk = ~clk;

  assign npc = redirect ? tgt : pc + 32'd4;

  fetch_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .pc           (pc),
    .npc          (npc),
    .redirect     (redirect),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .id_allowin   (id_allowin),
    .fetch_busy   (fetch_busy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [63:0] head;
    chk("inst_req", inst_req, (!m_out && m_q.size() < 2));
    chk("inst_addr", inst_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("fetch_busy", fetch_busy, m_out);
    chk("if_valid", if_valid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("if_pc", if_pc, head[63:32]);
      chk("if_inst", if_inst, head[31:0]);
    end
  endtask

  // Reference: at most one fetch outstanding, at most two words held, redirect kills everything.
  task automatic model_step();
    bit          hs, pop;
    logic [31:0] nxt;
    hs  = !m_out && m_q.size() < 2 && inst_addr_ok;
    nxt = redirect ? tgt : m_pc + 32'd4;
    pop = (m_q.size() != 0) && id_allowin;
    if (redirect) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (m_out && !m_kill && inst_data_ok) m_q.push_back({m_req_pc, inst_rdata});
    end
    if (m_out && inst_data_ok) m_out = 1'b0;
    else if (m_out && redirect) m_kill = 1'b1;
    if (hs) begin
      m_out    = 1'b1;
      m_kill   = redirect;
      m_req_pc = m_pc;
    end
    if (hs || redirect) m_pc = nxt;
  endtask

  task automatic tick();
    bit          hs;
    logic [31:0] a;
    @(negedge clk);
    check_model();
    hs = inst_req && inst_addr_ok;
    a  = inst_addr;
    model_step();
    if (hs) begin
      mem_cnt = lat;
      mem_dat = bad_word ? 32'hDEADBEEF : mem_word(a);
    end
    @(posedge clk);
    #1;
    if (mem_cnt == 1) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_dat;
      mem_cnt      = 0;
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0;
      if (mem_cnt > 1) mem_cnt--;
    end
  endtask

  task automatic do_reset();
    rstn         = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    inst_addr_ok = 1'b0;
    redirect     = 1'b0;
    tgt          = 32'h0;
    id_allowin   = 1'b0;
    mem_cnt      = 0;
    bad_word     = 1'b0;
    lat          = 1;
    m_pc         = RPC;
    m_req_pc     = 32'h0;
    m_out        = 1'b0;
    m_kill       = 1'b0;
    m_q.delete();
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_inst_req", inst_req, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_pc", pc, RPC);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2;
    // Free-run: one word every second cycle starting at cycle 2.
    do_reset();
    inst_addr_ok = 1'b1;
    id_allowin   = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c >= 2) begin
        chk("s1_if_valid", if_valid, (c % 2 == 0));
        if (c % 2 == 0) chk("s1_if_pc", if_pc, RPC + 32'(4 * (c / 2 - 1)));
      end
      tick();
    end

    // Stall: queue fills with two words, then requests stop.
    do_reset();
    inst_addr_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 4) begin
        chk("s2_stall_req", inst_req, 0);
        chk("s2_stall_head", if_pc, RPC);
      end
      tick();
    end
    id_allowin = 1'b1;
    chk("s2_rel_head0", if_pc, RPC);
    lat      = 2;
    bad_word = 1'b1;
    tick();
    chk("s2_rel_head1", if_pc, RPC + 32'h4);
    chk("s2_resume_req", inst_req, 1);
    chk("s2_resume_addr", inst_addr, RPC + 32'h8);

    // Redirect while waiting on 1c000008; its late DEADBEEF must vanish.
    tick();
    redirect = 1'b1;
    tgt      = RPC + 32'h100;
    bad_word = 1'b0;
    lat      = 1;
    chk("s3_wait_busy", fetch_busy, 1);
    tick();
    redirect = 1'b0;
    chk("s3_drop_pc", inst_addr, RPC + 32'h100);
    chk("s3_drop_req", inst_req, 0);
    tick();
    chk("s3_new_req", inst_req, 1);
    chk("s3_new_addr", inst_addr, RPC + 32'h100);
    chk("s3_no_stale", if_valid, 0);
    tick();
    tick();
    chk("s3_head_pc", if_pc, RPC + 32'h100);
    chk("s3_head_inst", if_inst, mem_word(RPC + 32'h100));

    // Redirect coinciding with the handshake for 1c00000c.
    do_reset();
    inst_addr_ok = 1'b1;
    id_allowin   = 1'b1;
    repeat (6) tick();
    chk("s4_pre_addr", inst_addr, RPC + 32'hc);
    redirect = 1'b1;
    tgt      = RPC + 32'h200;
    tick();
    redirect = 1'b0;
    chk("s4_drop_busy", fetch_busy, 1);
    chk("s4_drop_req", inst_req, 0);
    tick();
    chk("s4_req", inst_req, 1);
    chk("s4_addr", inst_addr, RPC + 32'h200);
    chk("s4_flushed", if_valid, 0);
    tick();
    tick();
    chk("s4_head", if_pc, RPC + 32'h200);

    // Redirect with a queued word and data_ok arriving in the same cycle.
    do_reset();
    inst_addr_ok = 1'b1;
    repeat (3) tick();
    chk("s5_pre_busy", fetch_busy, 1);
    chk("s5_pre_head", if_valid, 1);
    redirect = 1'b1;
    tgt      = RPC + 32'h300;
    tick();
    redirect   = 1'b0;
    id_allowin = 1'b1;
    chk("s5_flush_vld", if_valid, 0);
    chk("s5_req", inst_req, 1);
    chk("s5_addr", inst_addr, RPC + 32'h300);
    chk("s5_busy", fetch_busy, 0);
    tick();
    tick();
    chk("s5_head", if_pc, RPC + 32'h300);
    tick();

    // Reset pulsed while a fetch is outstanding, then a stray data_ok.
    chk("s6_pre_busy", fetch_busy, 1);
    do_reset();
    id_allowin = 1'b1;
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hBAD0BAD0;
    chk("s6_c1_addr", inst_addr, RPC);
    tick();
    inst_addr_ok = 1'b1;
    chk("s6_c2_vld", if_valid, 0);
    chk("s6_c2_busy", fetch_busy, 0);
    tick();
    chk("s6_c3_busy", fetch_busy, 1);
    tick();
    chk("s6_head_pc", if_pc, RPC);
    chk("s6_head_inst", if_inst, mem_word(RPC));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
